// File: rtl/mtl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mtl_pkg
//  Description : Shared display geometry, coordinate types and the touch
//                tracker state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mtl_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 480;

    typedef logic [9:0] x_coord_t;
    typedef logic [8:0] y_coord_t;

    typedef enum logic [1:0] {
        TP_IDLE    = 2'd0,
        TP_ACQUIRE = 2'd1,
        TP_TRACK   = 2'd2
    } touch_state_t;

endpackage
`default_nettype wire

// File: rtl/touch_point_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : touch_point_tracker_if
//  Description : Sample/frame inputs and published-point outputs of the
//                touch point tracker.
//                master : touch source / frame timing side (drives i*)
//                slave  : tracker side (drives o*)
//  Signals     : iTouchValid  1  sample strobe
//                iTouchCount  2  fingers reported (0 = released)
//                iX1 / iY1   10/9 raw first-point coordinates
//                iNewFrame    1  frame-start pulse
//                oX1 / oY1   10/9 published coordinates
//                oTouchCount  2  published finger count
//                oTouchReady  1  published point valid
//  Revision    : 1.0 - initial release
// ============================================================================
interface touch_point_tracker_if;
    import mtl_pkg::*;

    logic        iTouchValid;
    logic [1:0]  iTouchCount;
    x_coord_t    iX1;
    y_coord_t    iY1;
    logic        iNewFrame;
    x_coord_t    oX1;
    y_coord_t    oY1;
    logic [1:0]  oTouchCount;
    logic        oTouchReady;

    modport master (
        output iTouchValid, iTouchCount, iX1, iY1, iNewFrame,
        input  oX1, oY1, oTouchCount, oTouchReady
    );

    modport slave (
        input  iTouchValid, iTouchCount, iX1, iY1, iNewFrame,
        output oX1, oY1, oTouchCount, oTouchReady
    );

endinterface
`default_nettype wire

// File: rtl/touch_iir_axis.sv
`default_nettype none
// ============================================================================
//  Module      : touch_iir_axis
//  Description : One coordinate axis: clamps the raw sample to MAXV, then
//                either loads it directly or applies a first-order IIR step
//                f <= f + ((s - f) >>> SHIFT).
//  Ports       : i_clk, i_rst_n  clock / async active-low reset
//                i_sample        raw coordinate
//                i_load          take the clamped sample unsmoothed
//                i_update        apply one IIR step toward the sample
//                o_value         current filter value
//  Revision    : 1.0 - initial release
// ============================================================================
module touch_iir_axis #(
    parameter int W     = 10,
    parameter int MAXV  = 799,
    parameter int SHIFT = 2
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst_n,
    input  wire logic [W-1:0] i_sample,
    input  wire logic         i_load,
    input  wire logic         i_update,
    output logic      [W-1:0] o_value
);

    logic [W-1:0]        w_clamped;
    logic signed [W:0]   w_diff;
    logic [W-1:0]        value_d;
    logic [W-1:0]        value_q;

    assign w_clamped = (i_sample > W'(MAXV)) ? W'(MAXV) : i_sample;

    // One extra bit keeps the difference of two unsigned W-bit values exact.
    assign w_diff = $signed({1'b0, w_clamped}) - $signed({1'b0, value_q});

    always_comb begin
        value_d = value_q;
        if (i_load) begin
            value_d = w_clamped;
        end else if (i_update) begin
            // The step never overshoots the sample, so truncating back to
            // W bits is always exact.
            value_d = W'($signed({1'b0, value_q}) + (w_diff >>> SHIFT));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_value = value_q;

endmodule
`default_nettype wire

// File: rtl/touch_point_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : touch_point_tracker
//  Description : Turns raw single-point touch samples into stable display
//                coordinates: clamp to the active area, debounce touch-down,
//                smooth per axis, and publish only on frame-start pulses.
//  Ports       : iCLK    system clock
//                iRST_n  asynchronous active-low reset
//                bus     touch_point_tracker_if.slave (samples in, point out)
//  Revision    : 1.0 - initial release
// ============================================================================
module touch_point_tracker
    import mtl_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = 2,
    parameter int FILT_SHIFT       = 2,
    parameter int TIMEOUT_FRAMES   = 4
) (
    input  wire logic             iCLK,
    input  wire logic             iRST_n,
    touch_point_tracker_if.slave  bus
);

    localparam int DB_W = $clog2(DEBOUNCE_SAMPLES + 1) < 1 ? 1 : $clog2(DEBOUNCE_SAMPLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1) < 1 ? 1 : $clog2(TIMEOUT_FRAMES + 1);

    touch_state_t     state_d, state_q;
    logic [DB_W-1:0]  debounce_d, debounce_q;
    logic [TO_W-1:0]  timeout_d, timeout_q;
    logic [1:0]       count_d, count_q;
    x_coord_t         ox_d, ox_q;
    y_coord_t         oy_d, oy_q;
    logic [1:0]       oc_d, oc_q;
    logic             or_d, or_q;

    logic             w_load;
    logic             w_update;
    x_coord_t         w_fx;
    y_coord_t         w_fy;

    touch_iir_axis #(
        .W     (10),
        .MAXV  (H_ACTIVE - 1),
        .SHIFT (FILT_SHIFT)
    ) u_iir_x (
        .i_clk    (iCLK),
        .i_rst_n  (iRST_n),
        .i_sample (bus.iX1),
        .i_load   (w_load),
        .i_update (w_update),
        .o_value  (w_fx)
    );

    touch_iir_axis #(
        .W     (9),
        .MAXV  (V_ACTIVE - 1),
        .SHIFT (FILT_SHIFT)
    ) u_iir_y (
        .i_clk    (iCLK),
        .i_rst_n  (iRST_n),
        .i_sample (bus.iY1),
        .i_load   (w_load),
        .i_update (w_update),
        .o_value  (w_fy)
    );

    always_comb begin
        state_d    = state_q;
        debounce_d = debounce_q;
        timeout_d  = timeout_q;
        count_d    = count_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        oc_d       = oc_q;
        or_d       = or_q;
        w_load     = 1'b0;
        w_update   = 1'b0;

        // Publish from the registered state, so a sample arriving in the
        // same cycle only becomes visible at the following frame.
        if (bus.iNewFrame) begin
            if (state_q == TP_TRACK) begin
                ox_d = w_fx;
                oy_d = w_fy;
                oc_d = count_q;
                or_d = 1'b1;
            end else begin
                oc_d = 2'd0;
                or_d = 1'b0;
            end
        end

        if (bus.iTouchValid) begin
            // Any sample restarts the timeout, even one that coincides
            // with a frame pulse.
            timeout_d = '0;
            if (bus.iTouchCount == 2'd0) begin
                state_d    = TP_IDLE;
                debounce_d = '0;
            end else begin
                count_d = bus.iTouchCount;
                case (state_q)
                    TP_IDLE: begin
                        w_load     = 1'b1;
                        debounce_d = DB_W'(1);
                        state_d    = (DEBOUNCE_SAMPLES <= 1) ? TP_TRACK : TP_ACQUIRE;
                    end
                    TP_ACQUIRE: begin
                        w_update   = 1'b1;
                        debounce_d = debounce_q + DB_W'(1);
                        if (debounce_d >= DB_W'(DEBOUNCE_SAMPLES)) begin
                            state_d = TP_TRACK;
                        end
                    end
                    TP_TRACK: begin
                        w_update = 1'b1;
                    end
                    default: begin
                        state_d = TP_IDLE;
                    end
                endcase
            end
        end else if (bus.iNewFrame && (state_q != TP_IDLE)) begin
            // Reaching the limit forces release, and entering IDLE clears
            // the counter, so it never rests at the limit.
            if (timeout_q + TO_W'(1) >= TO_W'(TIMEOUT_FRAMES)) begin
                state_d    = TP_IDLE;
                timeout_d  = '0;
                debounce_d = '0;
            end else begin
                timeout_d = timeout_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= TP_IDLE;
            debounce_q <= '0;
            timeout_q  <= '0;
            count_q    <= 2'd0;
            ox_q       <= '0;
            oy_q       <= '0;
            oc_q       <= 2'd0;
            or_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            debounce_q <= debounce_d;
            timeout_q  <= timeout_d;
            count_q    <= count_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            oc_q       <= oc_d;
            or_q       <= or_d;
        end
    end

    assign bus.oX1         = ox_q;
    assign bus.oY1         = oy_q;
    assign bus.oTouchCount = oc_q;
    assign bus.oTouchReady = or_q;

endmodule
`default_nettype wire

// File: tb/tb_touch_point_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_touch_point_tracker
//  Description : Self-checking bench for touch_point_tracker: directed
//                vector table, reset sequences and randomized traffic
//                against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_touch_point_tracker;
    import mtl_pkg::*;

    localparam int DB = 2;
    localparam int FS = 2;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    touch_point_tracker_if bus ();

    touch_point_tracker #(
        .DEBOUNCE_SAMPLES (DB),
        .FILT_SHIFT       (FS),
        .TIMEOUT_FRAMES   (TO)
    ) dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: hits = consecutive touching samples since release
    // (capped at DB; tracking once it reaches DB), idle = quiet frames.
    int m_hits, m_idle, m_fx, m_fy, m_cnt;
    int m_ox, m_oy, m_oc, m_or;

    task automatic model_reset();
        m_hits = 0; m_idle = 0; m_fx = 0; m_fy = 0; m_cnt = 0;
        m_ox = 0; m_oy = 0; m_oc = 0; m_or = 0;
    endtask

    task automatic model_step(input bit v, input int c, input int x, input int y, input bit nf);
        int cx, cy;
        if (nf) begin
            if (m_hits >= DB) begin
                m_ox = m_fx; m_oy = m_fy; m_oc = m_cnt; m_or = 1;
            end else begin
                m_oc = 0; m_or = 0;
            end
        end
        if (v) begin
            m_idle = 0;
            if (c == 0) begin
                m_hits = 0;
            end else begin
                cx = (x > H_ACTIVE - 1) ? H_ACTIVE - 1 : x;
                cy = (y > V_ACTIVE - 1) ? V_ACTIVE - 1 : y;
                if (m_hits == 0) begin
                    m_fx = cx; m_fy = cy;
                end else begin
                    m_fx = m_fx + ((cx - m_fx) >>> FS);
                    m_fy = m_fy + ((cy - m_fy) >>> FS);
                end
                m_hits = (m_hits >= DB) ? DB : m_hits + 1;
                m_cnt  = c;
            end
        end else if (nf && m_hits > 0) begin
            m_idle++;
            if (m_idle >= TO) begin
                m_hits = 0; m_idle = 0;
            end
        end
    endtask

    task automatic check(input string nm, input int ex, input int ey, input int ec, input int er);
        int ax, ay, ac, ar;
        ax = int'(bus.oX1); ay = int'(bus.oY1);
        ac = int'(bus.oTouchCount); ar = int'(bus.oTouchReady);
        total++;
        if (ax != ex || ay != ey || ac != ec || ar != er) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d cnt=%0d rdy=%0d, want x=%0d y=%0d cnt=%0d rdy=%0d",
                     nm, ax, ay, ac, ar, ex, ey, ec, er);
        end
    endtask

    // Drive one cycle's inputs (called just after a falling edge), step the
    // model at the rising edge and return at the next falling edge.
    task automatic apply(input bit v, input int c, input int x, input int y, input bit nf);
        bus.iTouchValid = v;
        bus.iTouchCount = 2'(c);
        bus.iX1         = 10'(x);
        bus.iY1         = 9'(y);
        bus.iNewFrame   = nf;
        @(posedge clk);
        model_step(v, c, x, y, nf);
        @(negedge clk);
        bus.iTouchValid = 1'b0;
        bus.iNewFrame   = 1'b0;
    endtask

    typedef struct {
        bit v; int c; int x; int y; bit nf;
        int ex; int ey; int ec; int er;
    } vec_t;

    vec_t tbl [20];

    initial begin
        // Touch-down with debounce and one IIR step.
        tbl[0]  = '{1, 1, 200, 200, 0,   0,   0, 0, 0};
        tbl[1]  = '{1, 1, 240, 220, 0,   0,   0, 0, 0};
        tbl[2]  = '{0, 0,   0,   0, 1, 210, 205, 1, 1};
        // Release by zero-count sample: coords hold.
        tbl[3]  = '{1, 0,   0,   0, 0, 210, 205, 1, 1};
        tbl[4]  = '{0, 0,   0,   0, 1, 210, 205, 0, 0};
        // Clamp and debounce.
        tbl[5]  = '{1, 1, 900, 500, 0, 210, 205, 0, 0};
        tbl[6]  = '{0, 0,   0,   0, 1, 210, 205, 0, 0};
        tbl[7]  = '{1, 2, 900, 500, 0, 210, 205, 0, 0};
        tbl[8]  = '{0, 0,   0,   0, 1, 799, 479, 2, 1};
        // Re-touch at (100,100), then a sample coinciding with a frame.
        tbl[9]  = '{1, 0,   0,   0, 0, 799, 479, 2, 1};
        tbl[10] = '{1, 1, 100, 100, 0, 799, 479, 2, 1};
        tbl[11] = '{1, 1, 100, 100, 0, 799, 479, 2, 1};
        tbl[12] = '{0, 0,   0,   0, 1, 100, 100, 1, 1};
        tbl[13] = '{1, 1, 180, 100, 1, 100, 100, 1, 1};
        tbl[14] = '{0, 0,   0,   0, 1, 120, 100, 1, 1};
        // Frame timeout: 4 quiet frames, drop seen at the 5th.
        tbl[15] = '{0, 0,   0,   0, 1, 120, 100, 1, 1};
        tbl[16] = '{0, 0,   0,   0, 1, 120, 100, 1, 1};
        tbl[17] = '{0, 0,   0,   0, 1, 120, 100, 1, 1};
        tbl[18] = '{0, 0,   0,   0, 1, 120, 100, 0, 0};
        tbl[19] = '{0, 0,   0,   0, 0, 120, 100, 0, 0};

        bus.iTouchValid = 1'b0;
        bus.iTouchCount = 2'd0;
        bus.iX1         = '0;
        bus.iY1         = '0;
        bus.iNewFrame   = 1'b0;
        model_reset();

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.iTouchValid = 1'($urandom_range(0, 1));
            bus.iTouchCount = 2'($urandom_range(0, 3));
            bus.iX1         = 10'($urandom_range(0, 1023));
            bus.iY1         = 9'($urandom_range(0, 511));
            bus.iNewFrame   = 1'($urandom_range(0, 1));
            #1 check("reset_hold", 0, 0, 0, 0);
        end
        @(negedge clk);
        bus.iTouchValid = 1'b0;
        bus.iNewFrame   = 1'b0;
        rst_n = 1'b1;

        // After release, frames without a touch publish nothing.
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 1);
            check("post_reset", 0, 0, 0, 0);
        end

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].v, tbl[i].c, tbl[i].x, tbl[i].y, tbl[i].nf);
            check($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ec, tbl[i].er);
        end

        // Reset in the middle of tracking, between frames.
        apply(1, 1, 400, 300, 0);
        apply(1, 1, 400, 300, 0);
        apply(0, 0, 0, 0, 1);
        check("pre_midreset", 400, 300, 1, 1);
        #1 rst_n = 1'b0;
        #1 check("midreset", 0, 0, 0, 0);
        model_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);
        // First touch after reset loads without smoothing toward zero.
        apply(1, 2, 300, 200, 0);
        apply(1, 2, 300, 200, 0);
        apply(0, 0, 0, 0, 1);
        check("reload", 300, 200, 2, 1);

        // Randomized traffic; segments vary the sample density so that both
        // long tracking runs and frame timeouts occur.
        for (int seg = 0; seg < 30; seg++) begin
            int pv;
            pv = $urandom_range(0, 60);
            for (int k = 0; k < 60; k++) begin
                bit v, nf;
                int c, x, y;
                v  = ($urandom_range(0, 99) < pv);
                c  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
                x  = $urandom_range(0, 1023);
                y  = $urandom_range(0, 511);
                nf = ($urandom_range(0, 5) == 0);
                apply(v, c, x, y, nf);
                check("rand", m_ox, m_oy, m_oc, m_or);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
